// File: rtl/dma_bus_arbiter.sv
// DMA start/arbitration controller: issues DMA start commands on device edges, runs the BR/BG
// bus handshake with the CPU, and signals completion, watchdog expiry and lost requests.
module dma_bus_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned MAX_GRANT = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 dev_int,
  input  logic                 cpu_mem_busy,
  input  logic                 cpu_mem_req,
  input  logic                 BR,
  output logic                 BG,
  output logic                 cmd,
  output logic                 mem_sel,
  output logic                 cpu_stall,
  output logic                 dma_done,
  output logic                 dma_error,
  output logic                 pend_ovf,
  output logic [WORD_SIZE-1:0] grant_cycles
);

  localparam int unsigned CNT_W = $clog2(MAX_GRANT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_BR,
    S_WAIT_CPU,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_wdog;
  logic                 w_edge;
  logic                 r_dev_prev;
  logic                 r_pending;
  logic                 r_pend_ovf;
  logic                 r_bg;
  logic                 r_cmd;
  logic                 r_done;
  logic                 r_error;
  logic [CNT_W-1:0]     r_count;
  logic [WORD_SIZE-1:0] r_grant_cycles;

  assign w_edge = dev_int & ~r_dev_prev;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; w_wdog flags a forced release by the grant watchdog
  always_comb begin
    w_next = r_state;
    w_wdog = 1'b0;
    case (r_state)
      S_IDLE:     if (w_edge || r_pending) w_next = S_CMD;
      S_CMD:      w_next = S_WAIT_BR;
      S_WAIT_BR:  if (BR) w_next = cpu_mem_busy ? S_WAIT_CPU : S_GRANT;
      S_WAIT_CPU: if (!cpu_mem_busy) w_next = S_GRANT;
      S_GRANT: begin
        if (!BR) begin
          w_next = S_RELEASE;
        end else if (r_count == CNT_W'(MAX_GRANT)) begin
          w_next = S_RELEASE;
          w_wdog = 1'b1;
        end
      end
      S_RELEASE:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Registered outputs, request queue, grant counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dev_prev     <= 1'b0;
      r_pending      <= 1'b0;
      r_pend_ovf     <= 1'b0;
      r_bg           <= 1'b0;
      r_cmd          <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_count        <= '0;
      r_grant_cycles <= '0;
    end else begin
      r_dev_prev <= dev_int;
      r_cmd      <= (w_next == S_CMD);
      r_bg       <= (w_next == S_GRANT);
      r_done     <= (w_next == S_RELEASE);
      if (w_wdog) r_error <= 1'b1;

      // In IDLE any pending request is consumed by the CMD it triggers
      if (r_state == S_IDLE) begin
        if (w_edge && r_pending) r_pend_ovf <= 1'b1;
        r_pending <= 1'b0;
      end else if (w_edge) begin
        if (r_pending) r_pend_ovf <= 1'b1;
        r_pending <= 1'b1;
      end

      if (r_state != S_GRANT && w_next == S_GRANT) begin
        r_count <= CNT_W'(1);
      end else if (r_state == S_GRANT && w_next == S_GRANT &&
                   r_count != CNT_W'(MAX_GRANT)) begin
        r_count <= r_count + CNT_W'(1);
      end else if (r_state == S_RELEASE) begin
        r_grant_cycles <= WORD_SIZE'(r_count);
        r_count        <= '0;
      end
    end
  end

  assign BG           = r_bg;
  assign mem_sel      = r_bg;
  assign cpu_stall    = r_bg & cpu_mem_req;
  assign cmd          = r_cmd;
  assign dma_done     = r_done;
  assign dma_error    = r_error;
  assign pend_ovf     = r_pend_ovf;
  assign grant_cycles = r_grant_cycles;

endmodule
